dmem: RTL and testbench

// - RV32I data memory: word-organised RAM at 0x8000_0000 plus read-only N-number ID words at 0x0010_0000.
// - Sits behind the load/store path; the core drives address, store data, access type and read/write enables.
// - Writes are synchronous on clk; reads are combinational, with byte/half/word extraction and sign/zero extension.

---
 rtl/dmem.sv | 119 +++++++++++
 tb/tb_dmem.sv | 133 +++++++++++++
 2 files changed

// File: rtl/dmem.sv
// dmem: RV32I data memory.
//   - Word-organised RAM at RAM_BASE (DEPTH x 32 bit), cleared by an asynchronous reset.
//   - Three read-only ID words at ID_BASE, ID_BASE+4 and ID_BASE+8.
//   - Writes happen on the rising clock edge. Reads are combinational.
//   - Loads are extracted and extended as byte, half or word.
// Ports:
//   clk, rst_n  - clock; asynchronous active-low reset (clears RAM, forces out_data=0)
//   memread     - 1: out_data shows the addressed location, 0: out_data = 0
//   memwrite    - 1: store wr_data on the next rising edge (RAM hits only)
//   addr        - byte address
//   wr_data     - store data; sub-word stores use the low bits
//   data_type   - 0 sb/lb, 1 sh/lh, 2 word, 3 lbu, 4 lhu, 5-7 word
//   out_data    - load result

// One RAM word with per-byte write enables.
module dmem_word (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] d,
  output logic [31:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else if (we)
      for (int b = 0; b < 4; b++)
        if (be[b]) q[8*b +: 8] <= d[8*b +: 8];
  end
endmodule

module dmem #(
  parameter int          DEPTH    = 1024,
  parameter logic [31:0] RAM_BASE = 32'h8000_0000,
  parameter logic [31:0] ID_BASE  = 32'h0010_0000,
  parameter logic [31:0] N_NUM0   = 32'h0,
  parameter logic [31:0] N_NUM1   = 32'h0,
  parameter logic [31:0] N_NUM2   = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic [2:0]  data_type,
  output logic [31:0] out_data
);
  localparam int          AW     = $clog2(DEPTH);
  localparam logic [31:0] RAM_SZ = 32'(4 * DEPTH);
  localparam logic [29:0] ID_W   = ID_BASE[31:2];

  logic [31:0]             offset;
  logic                    ram_hit, id_hit;
  logic [AW-1:0]           idx;
  logic [DEPTH-1:0][31:0]  words;
  logic [DEPTH-1:0]        we;
  logic [3:0]              be;
  logic [31:0]             wd, rd_word, ext;
  logic [7:0]              rd_b;
  logic [15:0]             rd_h;

  // Offset compare avoids overflow when the RAM ends at the top of the address space.
  assign offset  = addr - RAM_BASE;
  assign ram_hit = (addr >= RAM_BASE) && (offset < RAM_SZ);
  assign idx     = offset[AW+1:2];
  assign id_hit  = (addr[31:2] == ID_W) || (addr[31:2] == ID_W + 30'd1) ||
                   (addr[31:2] == ID_W + 30'd2);

  // Sub-word stores replicate the data across lanes so the byte enables
  // alone pick the destination lane.
  always_comb begin
    be = 4'b1111;
    wd = wr_data;
    case (data_type)
      3'd0: begin be = 4'b0001 << addr[1:0]; wd = {4{wr_data[7:0]}};  end
      3'd1: begin be = addr[1] ? 4'b1100 : 4'b0011; wd = {2{wr_data[15:0]}}; end
      default: ;
    endcase
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign we[i] = memwrite && ram_hit && (idx == AW'(i));
    dmem_word u_word (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we[i]),
      .be    (be),
      .d     (wd),
      .q     (words[i])
    );
  end

  always_comb begin
    rd_word = '0;
    if (ram_hit) rd_word = words[idx];
    else if (id_hit)
      case (addr[3:2])
        2'd0:    rd_word = N_NUM0;
        2'd1:    rd_word = N_NUM1;
        default: rd_word = N_NUM2;
      endcase
  end

  assign rd_b = rd_word[8*addr[1:0] +: 8];
  assign rd_h = addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (data_type)
      3'd0:    ext = {{24{rd_b[7]}}, rd_b};
      3'd3:    ext = {24'h0, rd_b};
      3'd1:    ext = {{16{rd_h[15]}}, rd_h};
      3'd4:    ext = {16'h0, rd_h};
      default: ext = rd_word;
    endcase
  end

  assign out_data = (rst_n && memread) ? ext : 32'h0;
endmodule

// File: tb/tb_dmem.sv
// tb_dmem: directed checks of dmem (small RAM so the top boundary is reachable).
module tb_dmem;
  logic        clk = 1'b0;
  logic        rst_n, memread, memwrite;
  logic [31:0] addr, wr_data, out_data;
  logic [2:0]  data_type;
  int          errors = 0, checks = 0;

  dmem #(
    .DEPTH (16),
    .N_NUM0(32'hCAFE_0001),
    .N_NUM1(32'h1234_8765),
    .N_NUM2(32'h0BAD_F00D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .memread   (memread),
    .memwrite  (memwrite),
    .addr      (addr),
    .wr_data   (wr_data),
    .data_type (data_type),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] exp);
    checks++;
    assert (out_data === exp)
    else begin
      errors++;
      $error("FAIL %s: out_data=%h expected=%h", tag, out_data, exp);
    end
  endtask

  // Read-only look at a location: no write, settle, compare.
  task automatic rd(input string tag, input logic [31:0] a, input logic [2:0] t,
                    input logic [31:0] exp);
    memwrite = 1'b0; memread = 1'b1; addr = a; data_type = t;
    #1 check(tag, exp);
  endtask

  // Store, then let the edge pass.
  task automatic wr(input logic [31:0] a, input logic [2:0] t, input logic [31:0] d);
    memwrite = 1'b1; addr = a; data_type = t; wr_data = d;
    @(posedge clk); #1;
    memwrite = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; memread = 1'b1; memwrite = 1'b0;
    addr = 32'h8000_0000; wr_data = '0; data_type = 3'd2;
    #1 check("reset_out", 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ID words, read-only
    rd("id1_half", 32'h0010_0004, 3'd1, 32'hFFFF_8765);
    wr(32'h0010_0004, 3'd2, 32'h0);
    rd("id1_after_wr", 32'h0010_0004, 3'd1, 32'hFFFF_8765);
    rd("id1_word", 32'h0010_0004, 3'd2, 32'h1234_8765);
    rd("id0_word", 32'h0010_0000, 3'd2, 32'hCAFE_0001);
    rd("id2_word", 32'h0010_0008, 3'd2, 32'h0BAD_F00D);
    rd("id3_none", 32'h0010_000C, 3'd2, 32'h0);

    // unmapped store
    memread = 1'b1;
    wr(32'h0000_000C, 3'd2, 32'h1234_5678);
    rd("unmapped_rd", 32'h0000_000C, 3'd2, 32'h0);
    rd("ram3_untouched", 32'h8000_000C, 3'd2, 32'h0);

    // half store, byte-unsigned-typed (full word) store
    wr(32'h8000_000C, 3'd1, 32'h1234_5678);
    rd("ram3_half", 32'h8000_000C, 3'd1, 32'h0000_5678);
    rd("ram3_word", 32'h8000_000C, 3'd2, 32'h0000_5678);
    wr(32'h8000_0010, 3'd3, 32'h1234_5678);
    rd("ram4_lbu", 32'h8000_0010, 3'd3, 32'h0000_0078);
    rd("ram4_word", 32'h8000_0010, 3'd2, 32'h1234_5678);

    // extension variants
    wr(32'h8000_0020, 3'd2, 32'h0000_80F0);
    rd("lb_neg", 32'h8000_0020, 3'd0, 32'hFFFF_FFF0);
    rd("lh_neg", 32'h8000_0020, 3'd1, 32'hFFFF_80F0);
    rd("lhu", 32'h8000_0020, 3'd4, 32'h0000_80F0);
    rd("lb_lane1", 32'h8000_0021, 3'd0, 32'hFFFF_FF80);
    rd("lbu_lane1", 32'h8000_0021, 3'd3, 32'h0000_0080);
    rd("lw_type7", 32'h8000_0023, 3'd7, 32'h0000_80F0);

    // sub-word stores preserve neighbours
    wr(32'h8000_0022, 3'd0, 32'h0000_00AB);
    rd("sb_lane2", 32'h8000_0020, 3'd2, 32'h00AB_80F0);
    rd("lh_upper_a0", 32'h8000_0023, 3'd1, 32'h0000_00AB);
    wr(32'h8000_0026, 3'd1, 32'h0000_BEEF);
    rd("sh_upper", 32'h8000_0024, 3'd2, 32'hBEEF_0000);
    rd("lhu_lower0", 32'h8000_0024, 3'd4, 32'h0);

    // read and write together: old value before edge, new after
    memread = 1'b1; memwrite = 1'b1; addr = 32'h8000_0030;
    data_type = 3'd2; wr_data = 32'h1111_2222;
    #1 check("raw_before", 32'h0);
    @(posedge clk); #1;
    check("raw_after", 32'h1111_2222);
    memwrite = 1'b0;

    // range boundaries
    wr(32'h8000_003C, 3'd2, 32'h5555_AAAA);
    rd("last_word", 32'h8000_003C, 3'd2, 32'h5555_AAAA);
    wr(32'h8000_0040, 3'd2, 32'hDEAD_BEEF);
    rd("past_end", 32'h8000_0040, 3'd2, 32'h0);
    rd("no_alias", 32'h8000_0000, 3'd2, 32'h0);
    rd("below_base", 32'h7FFF_FFFC, 3'd2, 32'h0);

    // memread gating
    memread = 1'b0; addr = 32'h8000_0020;
    #1 check("memread0", 32'h0);

    // reset pulse clears contents; a write during reset is dropped
    memread = 1'b1; memwrite = 1'b1; addr = 32'h8000_0020;
    data_type = 3'd2; wr_data = 32'h7777_7777;
    #2 rst_n = 1'b0;
    #1 check("rst_low_out", 32'h0);
    @(posedge clk); #1;
    memwrite = 1'b0;
    rst_n = 1'b1;
    rd("rst_cleared20", 32'h8000_0020, 3'd2, 32'h0);
    rd("rst_cleared10", 32'h8000_0010, 3'd2, 32'h0);
    rd("rst_cleared3c", 32'h8000_003C, 3'd2, 32'h0);
    rd("id_after_rst", 32'h0010_0008, 3'd2, 32'h0BAD_F00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
